// File: rtl/banked_sram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : banked_sram_pkg
//  Description : Shared types and constant helpers for the banked SRAM.
//                state_e        - controller state (INIT clears, READY serves)
//                bank_sel_bits  - address bits used for bank select (0 if 1 bank)
//                bank_idx_w     - storage width of a bank index (min 1)
//                row_idx_w      - storage width of a row index (min 1)
//  Revision    : 1.0 - initial release
// ============================================================================
package banked_sram_pkg;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    function automatic int bank_sel_bits(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 0;
    endfunction

    function automatic int bank_idx_w(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

    function automatic int row_idx_w(input int num_words, input int num_banks);
        return ((num_words / num_banks) > 1) ? $clog2(num_words / num_banks) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_bank.sv
`default_nettype none
// ============================================================================
//  Module      : sram_bank
//  Description : One SRAM bank: row array with byte-masked write, registered
//                read, then READ_LATENCY-1 free-running delay registers.
//  Ports       : clk_i   - clock
//                we_i    - write strobe (bytes gated by be_i)
//                re_i    - read strobe, loads the read register
//                row_i   - row index for read or write
//                wdata_i - write data
//                be_i    - byte enables, bit i covers byte i
//                rdata_o - read data, valid READ_LATENCY cycles after re_i
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_bank
    import banked_sram_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int NUM_ROWS     = 512,
    parameter int ROW_W        = 9,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic                    re_i,
    input  logic [ROW_W-1:0]        row_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q     [NUM_ROWS];
    logic [DATA_WIDTH-1:0] rd_pipe_q [READ_LATENCY];

    // Storage is deliberately not reset; the top-level INIT sweep clears it.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (be_i[b]) begin
                    mem_q[row_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Stage 0 holds its value between reads; later stages shift every cycle,
    // so data read at edge T reaches the last stage at edge T+READ_LATENCY-1.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rd_pipe_q[0] <= mem_q[row_i];
        end
        for (int s = 1; s < READ_LATENCY; s++) begin
            rd_pipe_q[s] <= rd_pipe_q[s-1];
        end
    end

    assign rdata_o = rd_pipe_q[READ_LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/banked_sram.sv
`default_nettype none
// ============================================================================
//  Module      : banked_sram
//  Description : Multi-bank SRAM with post-reset zero-fill, byte-masked
//                writes and fixed-latency pipelined reads.
//  Ports       : clk_i, rst_ni       - clock, async active-low reset
//                req_i/gnt_o         - request / accept handshake
//                we_i, addr_i        - write select, word address
//                wdata_i, be_i       - write data, byte enables
//                rvalid_o, rdata_o   - read response (rdata_o holds when idle)
//                init_done_o         - zero-fill finished
//  Revision    : 1.0 - initial release
// ============================================================================
module banked_sram
    import banked_sram_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int NUM_WORDS    = 1024,
    parameter int NUM_BANKS    = 2,
    parameter int READ_LATENCY = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         req_i,
    output logic                         gnt_o,
    input  logic                         we_i,
    input  logic [$clog2(NUM_WORDS)-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0]        wdata_i,
    input  logic [DATA_WIDTH/8-1:0]      be_i,
    output logic                         rvalid_o,
    output logic [DATA_WIDTH-1:0]        rdata_o,
    output logic                         init_done_o
);

    localparam int BANK_BITS = bank_sel_bits(NUM_BANKS);
    localparam int BANK_W    = bank_idx_w(NUM_BANKS);
    localparam int NUM_ROWS  = NUM_WORDS / NUM_BANKS;
    localparam int ROW_W     = row_idx_w(NUM_WORDS, NUM_BANKS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

    state_e            state_q, state_d;
    logic [ROW_W-1:0]  init_row_q, init_row_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= INIT;
            init_row_q <= '0;
        end else begin
            state_q    <= state_d;
            init_row_q <= init_row_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_row_d = init_row_q;
        case (state_q)
            INIT: begin
                if (init_row_q == LAST_ROW) begin
                    state_d    = READY;
                    init_row_d = '0;
                end else begin
                    init_row_d = init_row_q + 1'b1;
                end
            end
            READY:   state_d = READY;
            default: state_d = INIT;
        endcase
    end

    logic in_init;
    logic accept, wr_acc, rd_acc;

    assign in_init     = (state_q == INIT);
    assign gnt_o       = (state_q == READY);
    assign init_done_o = (state_q == READY);
    assign accept      = req_i & gnt_o;
    assign wr_acc      = accept & we_i;
    assign rd_acc      = accept & ~we_i;

    // Address decode: low bits pick the bank, the rest pick the row.
    logic [BANK_W-1:0] req_bank;
    logic [ROW_W-1:0]  req_row;

    generate
        if (BANK_BITS > 0) begin : g_multi_bank
            assign req_bank = addr_i[BANK_BITS-1:0];
        end else begin : g_single_bank
            assign req_bank = '0;
        end
    endgenerate

    assign req_row = ROW_W'(addr_i >> BANK_BITS);

    // During INIT every bank writes zeros to the same row in parallel.
    logic [ROW_W-1:0]        bank_row;
    logic [DATA_WIDTH-1:0]   bank_wdata;
    logic [DATA_WIDTH/8-1:0] bank_be;
    logic [DATA_WIDTH-1:0]   bank_rdata [NUM_BANKS];

    assign bank_row   = in_init ? init_row_q : req_row;
    assign bank_wdata = in_init ? '0 : wdata_i;
    assign bank_be    = in_init ? '1 : be_i;

    generate
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            logic hit;
            assign hit = (req_bank == BANK_W'(b));

            sram_bank #(
                .DATA_WIDTH   (DATA_WIDTH),
                .NUM_ROWS     (NUM_ROWS),
                .ROW_W        (ROW_W),
                .READ_LATENCY (READ_LATENCY)
            ) u_bank (
                .clk_i   (clk_i),
                .we_i    (in_init | (wr_acc & hit)),
                .re_i    (rd_acc & hit),
                .row_i   (bank_row),
                .wdata_i (bank_wdata),
                .be_i    (bank_be),
                .rdata_o (bank_rdata[b])
            );
        end
    endgenerate

    // Valid and bank index travel together so the output mux always picks
    // the bank that served the read now emerging from the data pipeline.
    logic [READ_LATENCY-1:0] rvalid_pipe_q;
    logic [BANK_W-1:0]       bank_pipe_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [DATA_WIDTH-1:0]   out_mux;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_pipe_q <= '0;
            for (int s = 0; s < READ_LATENCY; s++) begin
                bank_pipe_q[s] <= '0;
            end
        end else begin
            rvalid_pipe_q[0] <= rd_acc;
            bank_pipe_q[0]   <= req_bank;
            for (int s = 1; s < READ_LATENCY; s++) begin
                rvalid_pipe_q[s] <= rvalid_pipe_q[s-1];
                bank_pipe_q[s]   <= bank_pipe_q[s-1];
            end
        end
    end

    assign rvalid_o = rvalid_pipe_q[READ_LATENCY-1];
    assign out_mux  = bank_rdata[bank_pipe_q[READ_LATENCY-1]];

    // Keeps the last delivered word visible between responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (rvalid_o) begin
            rdata_q <= out_mux;
        end
    end

    assign rdata_o = rvalid_o ? out_mux : rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_banked_sram.sv
`default_nettype none
// ============================================================================
//  Module      : tb_banked_sram
//  Description : Directed self-checking bench. Instance A uses default
//                parameters; instance B uses 64 words, 4 banks, latency 3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_banked_sram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults
    logic        a_rst_n, a_req, a_gnt, a_we, a_rvalid, a_init_done;
    logic [9:0]  a_addr;
    logic [63:0] a_wdata, a_rdata;
    logic [7:0]  a_be;

    // Instance B: 64 words, 4 banks, latency 3
    logic        b_rst_n, b_req, b_gnt, b_we, b_rvalid, b_init_done;
    logic [5:0]  b_addr;
    logic [63:0] b_wdata, b_rdata;
    logic [7:0]  b_be;

    banked_sram u_dut_a (
        .clk_i(clk), .rst_ni(a_rst_n), .req_i(a_req), .gnt_o(a_gnt),
        .we_i(a_we), .addr_i(a_addr), .wdata_i(a_wdata), .be_i(a_be),
        .rvalid_o(a_rvalid), .rdata_o(a_rdata), .init_done_o(a_init_done)
    );

    banked_sram #(
        .DATA_WIDTH(64), .NUM_WORDS(64), .NUM_BANKS(4), .READ_LATENCY(3)
    ) u_dut_b (
        .clk_i(clk), .rst_ni(b_rst_n), .req_i(b_req), .gnt_o(b_gnt),
        .we_i(b_we), .addr_i(b_addr), .wdata_i(b_wdata), .be_i(b_be),
        .rvalid_o(b_rvalid), .rdata_o(b_rdata), .init_done_o(b_init_done)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic a_idle();
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
    endtask

    task automatic b_idle();
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
    endtask

    // Each op is driven at a negedge and completes at the following negedge.
    task automatic a_write(input logic [9:0] addr, input logic [63:0] data, input logic [7:0] be);
        a_req = 1'b1; a_we = 1'b1; a_addr = addr; a_wdata = data; a_be = be;
        @(negedge clk);
        a_idle();
    endtask

    task automatic a_read(input logic [9:0] addr);
        a_req = 1'b1; a_we = 1'b0; a_addr = addr;
        @(negedge clk);
        a_idle();
    endtask

    task automatic b_write(input logic [5:0] addr, input logic [63:0] data);
        b_req = 1'b1; b_we = 1'b1; b_addr = addr; b_wdata = data; b_be = 8'hFF;
        @(negedge clk);
        b_idle();
    endtask

    task automatic a_count_init(output int n);
        n = 0;
        while (!a_gnt && n < 2000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic b_count_init(output int n, output int rv_seen);
        n = 0;
        rv_seen = 0;
        while (!b_gnt && n < 200) begin
            @(negedge clk);
            n++;
            if (b_rvalid !== 1'b0) rv_seen++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        int bad;
        int j;

        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_idle(); b_idle();
        repeat (3) @(negedge clk);

        // Reset state
        check("a_rst_gnt",       a_gnt,       0);
        check("a_rst_init_done", a_init_done, 0);
        check("a_rst_rvalid",    a_rvalid,    0);
        check("a_rst_rdata",     a_rdata,     0);
        check("b_rst_gnt",       b_gnt,       0);
        check("b_rst_rvalid",    b_rvalid,    0);

        // Zero-fill takes one cycle per row: 1024/2 = 512 cycles
        a_rst_n = 1'b1;
        a_count_init(n);
        check("a_init_cycles", n, 512);
        check("a_init_done",   a_init_done, 1);

        // Every address reads back zero, back-to-back reads
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            a_req = 1'b1; a_we = 1'b0; a_addr = 10'(i);
            @(negedge clk);
            if (a_rvalid !== 1'b1 || a_rdata !== 64'h0) bad++;
        end
        a_idle();
        check("a_zero_sweep_bad", bad, 0);
        @(negedge clk);
        check("a_sweep_rvalid_drop", a_rvalid, 0);

        // Byte-masked write, writes produce no rvalid
        a_write(10'd5, 64'h1122334455667788, 8'hFF);
        check("a_wr_no_rvalid", a_rvalid, 0);
        a_write(10'd5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        a_read(10'd5);
        check("a_be_read_valid", a_rvalid, 1);
        check("a_be_read_data",  a_rdata,  64'h11223344AAAAAAAA);
        @(negedge clk);
        check("a_idle_rvalid",   a_rvalid, 0);
        check("a_rdata_hold",    a_rdata,  64'h11223344AAAAAAAA);

        // Bank interleave: addr 4 (bank 0) then addr 5 (bank 1) back-to-back
        a_write(10'd4, 64'h44, 8'hFF);
        a_req = 1'b1; a_we = 1'b0; a_addr = 10'd4;
        @(negedge clk);
        check("a_ilv_data0", a_rdata, 64'h44);
        a_addr = 10'd5;
        @(negedge clk);
        a_idle();
        check("a_ilv_valid1", a_rvalid, 1);
        check("a_ilv_data1",  a_rdata,  64'h11223344AAAAAAAA);

        // Write then read same address next cycle
        a_write(10'd9, 64'hDEAD, 8'hFF);
        a_read(10'd9);
        check("a_raw_data", a_rdata, 64'hDEAD);

        // be=0 write is a no-op
        a_write(10'd9, 64'hFFFFFFFFFFFFFFFF, 8'h00);
        a_read(10'd9);
        check("a_be0_data", a_rdata, 64'hDEAD);

        // Requests during INIT are ignored
        a_write(10'd3, 64'h33, 8'hFF);
        a_req = 1'b1; a_we = 1'b1; a_addr = 10'd3; a_wdata = 64'hFFFFFFFFFFFFFFFF; a_be = 8'hFF;
        a_rst_n = 1'b0;
        @(negedge clk);
        a_rst_n = 1'b1;
        a_count_init(n);
        a_idle();
        check("a_reinit_cycles", n, 512);
        a_read(10'd3);
        check("a_init_req_valid", a_rvalid, 1);
        check("a_init_req_data",  a_rdata,  64'h0);

        // Instance B: 64/4 = 16 rows
        b_rst_n = 1'b1;
        b_count_init(n, seen);
        check("b_init_cycles", n, 16);

        // Reset mid-INIT restarts from row 0
        b_rst_n = 1'b0;
        @(negedge clk);
        b_rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("b_mid_init_gnt", b_gnt, 0);
        b_rst_n = 1'b0;
        @(negedge clk);
        b_rst_n = 1'b1;
        b_count_init(n, seen);
        check("b_restart_cycles", n, 16);

        // Latency-3 back-to-back reads across four banks
        for (int i = 0; i < 8; i++) b_write(6'(i), 64'(i));
        for (int k = 0; k < 13; k++) begin
            if (k < 8) begin
                b_req = 1'b1; b_we = 1'b0; b_addr = 6'(k);
            end else begin
                b_idle();
            end
            @(negedge clk);
            j = k - 2;
            check($sformatf("b_pipe_valid_%0d", k), b_rvalid, (j >= 0 && j < 8) ? 1 : 0);
            if (j >= 0 && j < 8) check($sformatf("b_pipe_data_%0d", j), b_rdata, 64'(j));
        end

        // Reset with a read in flight: no response after release
        b_req = 1'b1; b_we = 1'b0; b_addr = 6'd2;
        @(negedge clk);
        b_idle();
        b_rst_n = 1'b0;
        #1;
        check("b_inflight_rst_rvalid", b_rvalid, 0);
        @(negedge clk);
        b_rst_n = 1'b1;
        b_count_init(n, seen);
        check("b_inflight_reinit_cycles", n, 16);
        check("b_inflight_rvalid_seen",   seen, 0);
        repeat (3) @(negedge clk);
        check("b_inflight_quiet", b_rvalid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/banked_sram.md
BANKED_SRAM -- requirements
Module: banked_sram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, word width in bits; multiple of 8.
REQ-002 SHALL have parameter NUM_WORDS, default 1024, total words; power of 2.
REQ-003 SHALL have parameter NUM_BANKS, default 2, bank count; power of 2, 1..8, at most NUM_WORDS.
REQ-004 SHALL have parameter READ_LATENCY, default 1, cycles from accepted read to rvalid_o; range 1..3.
REQ-005 SHALL have port clk_i  in  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst_ni  in  1  asynchronous active-low reset.
REQ-007 SHALL have port req_i  in  1  access request.
REQ-008 SHALL have port gnt_o  out  1  request accepted this cycle when req_i&gnt_o.
REQ-009 SHALL have port we_i  in  1  1=write, 0=read.
REQ-010 SHALL have port addr_i  in  $clog2(NUM_WORDS)  word address.
REQ-011 SHALL have port wdata_i  in  DATA_WIDTH  write data.
REQ-012 SHALL have port be_i  in  DATA_WIDTH/8  byte enables, bit i covers byte i.
REQ-013 SHALL have port rvalid_o  out  1  rdata_o valid this cycle.
REQ-014 SHALL have port rdata_o  out  DATA_WIDTH  read data.
REQ-015 SHALL have port init_done_o  out  1  post-reset clear complete.

Function
REQ-016 Bank select SHALL be addr_i[$clog2(NUM_BANKS)-1:0]; row SHALL be remaining upper bits; NUM_BANKS=1 uses whole address as row.
REQ-017 FSM SHALL have states INIT and READY; reset enters INIT.
REQ-018 INIT: row counter 0..NUM_WORDS/NUM_BANKS-1, one row per cycle, SHALL write zero to that row in all banks in parallel; after last row -> READY.
REQ-019 gnt_o SHALL be 0 in INIT, 1 in READY; init_done_o SHALL equal (state==READY).
REQ-020 Accepted write SHALL update only bytes with be_i set; be_i=0 is a legal no-op write; no rvalid_o generated.
REQ-021 Accepted read at edge T SHALL assert rvalid_o for exactly one cycle starting READ_LATENCY cycles after T, with data of the addressed word as stored before edge T.
REQ-022 Back-to-back accepted reads SHALL produce back-to-back rvalid_o pulses in request order, one per cycle.
REQ-023 Write at edge T then read same address at edge T+1 SHALL return the new data.
REQ-024 Bank index of each read SHALL be pipelined alongside rvalid so output mux selects correct bank for every in-flight read.
REQ-025 rdata_o SHALL hold its last valid value while rvalid_o=0.
REQ-026 req_i without gnt_o SHALL be ignored (no write, no rvalid_o); requester must hold request.
REQ-027 Address/data X with req_i=0 SHALL not affect state.

Reset
REQ-028 On rst_ni low: state=INIT, row counter=0, gnt_o=0, init_done_o=0, rvalid_o=0, rvalid/bank pipelines=0, rdata_o=0.
REQ-029 Reset mid-read SHALL discard in-flight reads (no rvalid_o after release); reset mid-INIT SHALL restart clear from row 0.
REQ-030 Memory arrays SHALL not be reset directly; contents are defined only after INIT completes.

Structure
REQ-031 Package banked_sram_pkg SHALL hold the state enum (INIT, READY) and helper constant functions for bank/row index widths.
REQ-032 One sub-module sram_bank SHALL implement a single bank: row array, byte-masked write, registered read; instantiated NUM_BANKS times via generate.
REQ-033 Top level SHALL hold FSM, init counter, request decode, rvalid/bank pipelines and output mux.
REQ-034 Extra READ_LATENCY-1 stages SHALL be plain registers after the bank read register.

Verification
REQ-035 Reset, release, count cycles -> gnt_o=0 for exactly 512 cycles (defaults), then gnt_o=1, init_done_o=1; read of every address returns 0.
REQ-036 Write 0x1122334455667788 to addr 5, be=0xFF; then write 0xAAAAAAAAAAAAAAAA be=0x0F; read 5 -> 0x11223344AAAAAAAA, rvalid_o 1 cycle after accept.
REQ-037 READ_LATENCY=3, NUM_BANKS=4: write addr 0..7 with value=addr, read 0..7 back-to-back -> eight consecutive rvalid_o pulses, data 0..7 in order, first at accept+3.
REQ-038 Write addr 9 data 0xDEAD at T, read addr 9 at T+1 -> 0xDEAD.
REQ-039 Issue read, assert rst_ni low before rvalid_o -> no rvalid_o after release; gnt_o low again for full INIT.
REQ-040 req_i=1 during INIT with we_i=1 to addr 3 -> after INIT, read addr 3 returns 0.
